// File: rtl/imm_narrow_saturator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : imm_narrow_saturator
//  Description : Narrows signed IN_W-bit words to signed OUT_W-bit immediates.
//                Each word is range-checked, then saturated or wrapped, and
//                buffered as {ovf, result} in a 2-entry valid/ready FIFO.
//                Overflow statistics (sticky flag and saturating counter)
//                are updated on every accepted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_narrow_saturator #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 17,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stats
);

  localparam int HI_W = IN_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] c_sat_pos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_sat_neg = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [1:0]       c_full    = 2'd2;

  // FIFO state
  logic [1:0]       count_q,  count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OUT_W:0]   mem_q [2];
  logic [OUT_W:0]   mem_d [2];
  // Last popped entry, presented while the FIFO is empty
  logic [OUT_W:0]   last_q,   last_d;

  // Statistics state
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [HI_W-1:0]  w_hi;
  logic             w_ovf;
  logic [OUT_W-1:0] w_result;
  logic             w_push;
  logic             w_pop;
  logic [OUT_W:0]   w_head;

  // Handshake decode uses registered count only, so out_ready never reaches in_ready
  assign in_ready  = (count_q != c_full);
  assign out_valid = (count_q != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_head    = mem_q[rd_ptr_q];
  assign out_ovf   = out_valid ? w_head[OUT_W]        : last_q[OUT_W];
  assign out_data  = out_valid ? w_head[OUT_W-1:0]    : last_q[OUT_W-1:0];

  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

  // Range check: bits above the output sign bit must all copy the sign
  assign w_hi  = in_data[IN_W-1:OUT_W-1];
  assign w_ovf = ~((&w_hi) | ~(|w_hi));

  // Narrowed value: saturate to the nearest bound or keep the low bits
  always_comb begin
    w_result = in_data[OUT_W-1:0];
    if (w_ovf && (SAT_EN != 0)) begin
      w_result = in_data[IN_W-1] ? c_sat_neg : c_sat_pos;
    end
  end

  // FIFO next state: write on push, advance head on pop
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
    if (w_push) begin
      mem_d[wr_ptr_q] = {w_ovf, w_result};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
      last_d   = w_head;
    end
  end

  // Statistics next state: clear first, then account for an overflowing push
  always_comb begin
    sticky_d = clr_stats ? 1'b0 : sticky_q;
    cnt_d    = clr_stats ? '0   : cnt_q;
    if (w_push && w_ovf) begin
      sticky_d = 1'b1;
      if (cnt_d != c_cnt_max) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      last_q   <= last_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_narrow_saturator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_imm_narrow_saturator
//  Description : Self-checking bench. Three instances share one stimulus:
//                u0 saturating, u1 wrapping, u2 saturating with a 2-bit
//                overflow counter. A scoreboard queue holds expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_narrow_saturator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        clr_stats;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [16:0] od0, od1, od2;
  logic        oo0, oo1, oo2;
  logic        st0, st1, st2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clock = ~clock;

  imm_narrow_saturator #(.IN_W(32), .OUT_W(17), .SAT_EN(1), .CNT_W(16)) u0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ovf(oo0), .ovf_sticky(st0), .ovf_count(cnt0), .clr_stats(clr_stats));

  imm_narrow_saturator #(.IN_W(32), .OUT_W(17), .SAT_EN(0), .CNT_W(16)) u1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ovf(oo1), .ovf_sticky(st1), .ovf_count(cnt1), .clr_stats(clr_stats));

  imm_narrow_saturator #(.IN_W(32), .OUT_W(17), .SAT_EN(1), .CNT_W(2)) u2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_ovf(oo2), .ovf_sticky(st2), .ovf_count(cnt2), .clr_stats(clr_stats));

  int n_pass  = 0;
  int n_total = 0;
  int n_push  = 0;
  bit armed   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: bit 17 = overflow, bits 16:0 = narrowed value
  function automatic logic [17:0] model(input logic [31:0] d, input bit sat);
    logic [15:0] hi;
    logic        ovf;
    logic [16:0] res;
    hi  = d[31:16];
    ovf = !((hi == 16'h0000) || (hi == 16'hFFFF));
    res = d[16:0];
    if (ovf && sat) res = d[31] ? 17'h10000 : 17'h0FFFF;
    return {ovf, res};
  endfunction

  typedef struct {
    logic [31:0] din;
    logic        ovf;
    logic [16:0] dsat;
    logic [16:0] dwrap;
  } sb_t;

  sb_t         sbq[$];
  logic [15:0] cnt_m [3];
  logic        st_m  [3];

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    sb_t         e;
    logic [17:0] ms, mw;
    logic        push;
    logic        irk, ovk, stk, ook;
    logic [16:0] odk;
    logic [15:0] cntk, cmax;
    if (armed) begin
      push = in_valid && ir0;
      if (!reset_n) begin
        sbq.delete();
        for (int k = 0; k < 3; k++) begin
          st_m[k]  = 1'b0;
          cnt_m[k] = 16'd0;
        end
        chk("rst_out_valid", {ov0, ov1, ov2}, 3'b000);
        chk("rst_in_ready", {ir0, ir1, ir2}, 3'b111);
        chk("rst_count", {cnt0, cnt1, 14'd0, cnt2}, 32'd0);
      end else begin
        for (int k = 0; k < 3; k++) begin
          irk  = (k == 0) ? ir0  : (k == 1) ? ir1  : ir2;
          ovk  = (k == 0) ? ov0  : (k == 1) ? ov1  : ov2;
          stk  = (k == 0) ? st0  : (k == 1) ? st1  : st2;
          cntk = (k == 0) ? cnt0 : (k == 1) ? cnt1 : {14'd0, cnt2};
          chk($sformatf("in_ready[%0d]", k), irk, (sbq.size() != 2));
          chk($sformatf("out_valid[%0d]", k), ovk, (sbq.size() != 0));
          chk($sformatf("ovf_sticky[%0d]", k), stk, st_m[k]);
          chk($sformatf("ovf_count[%0d]", k), cntk, cnt_m[k]);
        end
        if (out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          for (int k = 0; k < 3; k++) begin
            odk = (k == 0) ? od0 : (k == 1) ? od1 : od2;
            ook = (k == 0) ? oo0 : (k == 1) ? oo1 : oo2;
            chk($sformatf("sb_data[%0d]", k), odk, (k == 1) ? e.dwrap : e.dsat);
            chk($sformatf("sb_ovf[%0d]", k), ook, e.ovf);
            if (!e.ovf) chk($sformatf("sext_roundtrip[%0d]", k), {{15{odk[16]}}, odk}, e.din);
          end
        end
        if (push) begin
          ms      = model(in_data, 1'b1);
          mw      = model(in_data, 1'b0);
          e.din   = in_data;
          e.ovf   = ms[17];
          e.dsat  = ms[16:0];
          e.dwrap = mw[16:0];
          sbq.push_back(e);
          n_push++;
        end
        ms = model(in_data, 1'b1);
        for (int k = 0; k < 3; k++) begin
          cmax = (k == 2) ? 16'd3 : 16'hFFFF;
          if (clr_stats) begin
            st_m[k]  = 1'b0;
            cnt_m[k] = 16'd0;
          end
          if (push && ms[17]) begin
            st_m[k] = 1'b1;
            if (cnt_m[k] != cmax) cnt_m[k] = cnt_m[k] + 16'd1;
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] din;
    logic        ovf;
    logic [16:0] dsat;
    logic [16:0] dwrap;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] bnd [6];

  initial begin
    int cyc;
    tbl[0] = '{32'h0000FFFF, 1'b0, 17'h0FFFF, 17'h0FFFF};
    tbl[1] = '{32'hFFFF0000, 1'b0, 17'h10000, 17'h10000};
    tbl[2] = '{32'h00010000, 1'b1, 17'h0FFFF, 17'h10000};
    tbl[3] = '{32'h80000000, 1'b1, 17'h10000, 17'h00000};
    tbl[4] = '{32'h12345678, 1'b1, 17'h0FFFF, 17'h05678};
    tbl[5] = '{32'h00000000, 1'b0, 17'h00000, 17'h00000};
    tbl[6] = '{32'hFFFFFFFF, 1'b0, 17'h1FFFF, 17'h1FFFF};
    tbl[7] = '{32'hFFFEFFFF, 1'b1, 17'h10000, 17'h0FFFF};
    tbl[8] = '{32'h7FFFFFFF, 1'b1, 17'h0FFFF, 17'h1FFFF};
    bnd[0] = 32'h0000FFFF; bnd[1] = 32'h00010000; bnd[2] = 32'hFFFF0000;
    bnd[3] = 32'hFFFEFFFF; bnd[4] = 32'h7FFFFFFF; bnd[5] = 32'h80000000;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    step();
    armed = 1'b1;
    step();

    // Reset state
    chk("reset_out_valid", ov0, 1'b0);
    chk("reset_out_data", od0, 17'd0);
    chk("reset_out_ovf", oo0, 1'b0);
    chk("reset_sticky", st0, 1'b0);
    chk("reset_count", cnt0, 16'd0);
    chk("reset_in_ready", ir0, 1'b1);
    reset_n = 1'b1;
    step();

    // Table vectors: each word lands at the head right after its push edge
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), ov0, 1'b1);
      chk($sformatf("vec%0d_sat_data", i), od0, tbl[i].dsat);
      chk($sformatf("vec%0d_sat_ovf", i), oo0, tbl[i].ovf);
      chk($sformatf("vec%0d_wrap_data", i), od1, tbl[i].dwrap);
      chk($sformatf("vec%0d_wrap_ovf", i), oo1, tbl[i].ovf);
      step();
    end
    chk("table_count_16b", cnt0, 16'd5);
    chk("table_count_2b_sat", cnt2, 2'd3);
    chk("table_sticky", st0, 1'b1);

    // Clear coinciding with an overflowing push
    clr_stats = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h80000000;
    step();
    clr_stats = 1'b0;
    in_valid  = 1'b0;
    chk("clr_push_count", cnt0, 16'd1);
    chk("clr_push_count_2b", cnt2, 2'd1);
    chk("clr_push_sticky", st0, 1'b1);
    step();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_count", cnt0, 16'd0);
    chk("clr_sticky", st0, 1'b0);

    // Backpressure: 1,2 buffered, 3 held by the source
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    step();
    in_data = 32'd2;
    step();
    chk("bp_full_in_ready", ir0, 1'b0);
    in_data = 32'd3;
    step();
    step();
    chk("bp_hold_data", od0, 17'd1);
    chk("bp_hold_in_ready", ir0, 1'b0);
    out_ready = 1'b1;
    chk("bp_release_head1", od0, 17'd1);
    step();
    chk("bp_head2", od0, 17'd2);
    chk("bp_in_ready_back", ir0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_head3", od0, 17'd3);
    chk("bp_head3_valid", ov0, 1'b1);
    step();
    chk("bp_empty", ov0, 1'b0);
    chk("bp_hold_last", od0, 17'd3);

    // Asynchronous reset with two overflowing words buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00010000;
    step();
    in_data = 32'h80000000;
    step();
    in_valid = 1'b0;
    chk("arst_pre_count", cnt0, 16'd2);
    chk("arst_pre_in_ready", ir0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {ov0, ov1, ov2}, 3'b000);
    chk("arst_in_ready", {ir0, ir1, ir2}, 3'b111);
    chk("arst_count", cnt0, 16'd0);
    chk("arst_sticky", st0, 1'b0);
    #5;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();

    // Randomized stream checked by the scoreboard
    n_push = 0;
    cyc    = 0;
    while (n_push < 10000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: in_data = $urandom;
        1: in_data = 32'($urandom_range(0, 131071)) - 32'h00010000;
        2: in_data = bnd[$urandom_range(0, 5)];
        default: in_data = 32'($urandom_range(0, 7)) - 32'd4;
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      clr_stats = ($urandom_range(0, 99) == 0);
      step();
      cyc++;
    end
    chk("rand_push_budget", (n_push >= 10000), 1'b1);

    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", ov0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_narrow_saturator.md
Name: imm_narrow_saturator

Overview:
Narrows a stream of 32-bit signed words to the 17-bit signed immediate format used by the datapath. It is the inverse path of the 17-to-32 immediate sign extension. Each word is range-checked and then either saturated or wrapped, and the result is buffered in a 2-entry FIFO with valid/ready handshakes on both sides. Overflow statistics are kept for the controller, for example when computing plotter step offsets that must fit an I-type immediate field.

Parameters:
IN_W, 32, input word width (signed)
OUT_W, 17, output word width (signed); must be less than IN_W
SAT_EN, 1, 1 = saturate on overflow; 0 = wrap (keep the low OUT_W bits)
CNT_W, 16, width of the overflow event counter

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
in_data  input  IN_W  signed source word
out_valid  output  1  out_data/out_ovf are valid
out_ready  input  1  consumer accepts the head word this cycle
out_data  output  OUT_W  narrowed signed word
out_ovf  output  1  head word was out of range
ovf_sticky  output  1  at least one overflow since reset/clear
ovf_count  output  CNT_W  number of overflowing words accepted (saturating)
clr_stats  input  1  synchronous clear of ovf_sticky/ovf_count

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FIFO count=0, both entries=0.
  - out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
  - in_ready=1 (count<2).
  - Deassertion takes effect at the next clock edge. A reset mid-stream discards any buffered words.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != 2), decoded from registered state only. There is no combinational path from out_ready to in_ready.
- Range check: ovf = 1 when in_data[IN_W-1:OUT_W-1] is not all-equal, i.e. the value is outside [-65536, 65535].
- Result computation:
  - ovf=0: result = in_data[OUT_W-1:0].
  - ovf=1, SAT_EN=1: result = 0x0FFFF (65535) if in_data[IN_W-1]=0, else 0x10000 (-65536).
  - ovf=1, SAT_EN=0: result = in_data[OUT_W-1:0].
- Storage: result and ovf are computed at push time and stored together as {ovf, result}.
- Latency: a word pushed at edge N appears on out_data/out_valid immediately after edge N when the FIFO was empty. Throughput is 1 word/cycle with no bubbles under continuous out_ready=1.
- FIFO: 2 entries with separate read and write pointers, each 1 bit and wrapping 1->0.
  - count=0: out_valid=0; out_data/out_ovf hold their last value (0 after reset).
  - count=1, push & pop: count stays 1; the head advances to the new word.
  - count=2: in_ready=0, so no push occurs. A pop returns count to 1.
  - While out_valid=1 & out_ready=0: out_data and out_ovf stay stable.
- Statistics (updated on push only, not on pop):
  - A push with ovf=1 sets ovf_sticky and increments ovf_count, which saturates at 2^CNT_W-1 with no wrap.
  - clr_stats=1 clears both. If it coincides with an overflowing push, the result is ovf_sticky=1 and ovf_count=1.
- Invariant: when out_ovf=0, sign-extending out_data to IN_W bits reproduces the accepted in_data exactly.

Test Plan:
- Reset release, in_data=0x0000FFFF pushed, out_ready=1 -> next cycle out_data=0x0FFFF, out_ovf=0, ovf_count=0; in_data=0xFFFF0000 -> out_data=0x10000, out_ovf=0.
- SAT_EN=1 overflow: in_data=0x00010000 -> out_data=0x0FFFF, out_ovf=1, ovf_sticky=1, ovf_count=1; in_data=0x80000000 -> out_data=0x10000, ovf_count=2.
- SAT_EN=0 overflow: in_data=0x12345678 -> out_data=0x05678, out_ovf=1, ovf_count=1.
- Backpressure: out_ready=0, push 3 consecutive words (1,2,3) -> in_ready falls after the 2nd push, the 3rd word is held by the source, out_data stays 1; release out_ready -> outputs 1,2,3 in order with no loss or duplication.
- Counter edges: CNT_W=2, push 5 overflowing words -> ovf_count stops at 3; clr_stats asserted with an overflowing push -> ovf_count=1, ovf_sticky=1.
- Asynchronous reset asserted mid-stream with 2 words buffered -> out_valid=0, in_ready=1 and ovf_count=0 immediately, without waiting for a clock edge; randomized stream of 10k words checked against the range-check/saturation model plus the sign-extension round-trip invariant.
